// File: rtl/shared_mem_arb_if.sv
// Request/response bundle between the requesters and the shared memory arbiter.
// Per-channel fields are packed flat: channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
// and [k*WIDTH +: WIDTH].
interface shared_mem_arb_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_CH     = 2
);
   logic [NUM_CH-1:0]            req;
   logic [NUM_CH-1:0]            we;
   logic [NUM_CH*ADDR_WIDTH-1:0] addr;
   logic [NUM_CH*WIDTH-1:0]      wdata;
   logic [NUM_CH-1:0]            gnt;
   logic [NUM_CH-1:0]            rvalid;
   logic [WIDTH-1:0]             rdata;
   logic                         err;
   logic                         init_done;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, err, init_done
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, err, init_done
   );
endinterface

// File: rtl/shared_mem_arb.sv
// Shared WIDTH x DEPTH scratch memory for NUM_CH requesters behind a
// round-robin arbiter. After reset the array is zero-filled one word per
// cycle (CLEAR) before any grant is issued (RUN). One access per cycle;
// reads return on rdata with a one-cycle rvalid pulse for the owning channel.
module shared_mem_arb #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_CH     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   shared_mem_arb_if.slave   bus
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        sel_idx;
   logic                    found;
   logic [NUM_CH-1:0]       gnt_c;
   logic                    init_c;
   logic                    xfer;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [WIDTH-1:0]        sel_wdata;
   logic                    in_range;
   logic [NUM_CH-1:0]       rvalid_q;
   logic [WIDTH-1:0]        rdata_q;
   logic                    err_q;

   logic [WIDTH-1:0]        mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   ch_addr  [NUM_CH];
   logic [WIDTH-1:0]        ch_wdata [NUM_CH];

   // Unpack the flat per-channel buses so the selected channel is a plain index.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_addr[k]  = bus.addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign ch_wdata[k] = bus.wdata[k*WIDTH +: WIDTH];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nx;
   end

   // Leave CLEAR on the edge that zeroes the last word.
   always_comb begin
      state_nx = state;
      if (state == CLEAR && clr_cnt == ADDR_WIDTH'(DEPTH - 1))
         state_nx = RUN;
   end

   // Round-robin search: first requesting channel at or above rr_ptr, wrapping.
   always_comb begin
      int              idx;
      logic [PTR_W-1:0] idx_l;
      found   = 1'b0;
      sel_idx = '0;
      idx     = 0;
      idx_l   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         idx_l = PTR_W'(idx);
         if (!found && bus.req[idx_l]) begin
            found   = 1'b1;
            sel_idx = idx_l;
         end
      end
   end

   // FSM outputs: grants only exist in RUN; init_done marks RUN.
   always_comb begin
      gnt_c  = '0;
      init_c = 1'b0;
      if (state == RUN) begin
         init_c = 1'b1;
         if (found) gnt_c[sel_idx] = 1'b1;
      end
   end

   assign xfer      = (state == RUN) && found;
   assign sel_we    = bus.we[sel_idx];
   assign sel_addr  = ch_addr[sel_idx];
   assign sel_wdata = ch_wdata[sel_idx];
   assign in_range  = int'(sel_addr) < DEPTH;

   // Storage write port: zero-fill during CLEAR, in-range writes during RUN.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[clr_cnt] <= '0;
      else if (xfer && sel_we && in_range)
         mem[sel_addr] <= sel_wdata;
   end

   // Clear counter, rr pointer and the registered read/err response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt  <= '0;
         rr_ptr   <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= '0;
         err_q    <= 1'b0;
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
         end else if (xfer) begin
            rr_ptr <= (sel_idx == PTR_W'(NUM_CH - 1)) ? '0 : sel_idx + PTR_W'(1);
            err_q  <= !in_range;
            if (!sel_we) begin
               rvalid_q[sel_idx] <= 1'b1;
               // Out-of-range reads still complete, returning zero.
               rdata_q <= in_range ? mem[sel_addr] : '0;
            end
         end
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.init_done = init_c;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_shared_mem_arb.sv
// Randomized + directed bench for shared_mem_arb against a behavioural model
// (array memory, integer rr pointer, cycle-count clear).
module tb_shared_mem_arb;
   localparam int W     = 8;
   localparam int DEPTH = 12;
   localparam int AW    = 4;
   localparam int NC    = 3;
   localparam int PW    = $clog2(NC);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NC-1:0] t_req, t_we;
   logic [AW-1:0] t_addr [NC];
   logic [W-1:0]  t_wd   [NC];

   shared_mem_arb_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();

   assign bus.req = t_req;
   assign bus.we  = t_we;
   for (genvar k = 0; k < NC; k++) begin : g_drv
      assign bus.addr[k*AW +: AW] = t_addr[k];
      assign bus.wdata[k*W +: W]  = t_wd[k];
   end

   shared_mem_arb #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // reference model state
   logic [W-1:0]  m_mem [DEPTH];
   int            m_rr, m_clr;
   logic          m_init;
   logic [NC-1:0] m_rv, m_gnt_last;
   logic [W-1:0]  m_rd;
   logic          m_err;

   int n_chk, n_pass;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_rr = 0; m_clr = 0; m_init = 1'b0;
      m_rv = '0; m_rd = '0; m_err = 1'b0; m_gnt_last = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
   endtask

   function automatic logic [NC-1:0] exp_gnt();
      logic [NC-1:0] g;
      logic [PW-1:0] kv;
      g = '0;
      if (m_init) begin
         for (int i = 0; i < NC; i++) begin
            kv = PW'((m_rr + i) % NC);
            if (g == '0 && t_req[kv]) g[kv] = 1'b1;
         end
      end
      return g;
   endfunction

   // one clock: check outputs mid-cycle, advance the model, end at posedge+1
   task automatic cycle(output logic [NC-1:0] g_obs);
      logic [NC-1:0] g;
      logic [PW-1:0] kv;
      logic [AW-1:0] a;
      @(negedge clk);
      g = exp_gnt();
      chk("gnt",       32'(bus.gnt),       32'(g));
      chk("rvalid",    32'(bus.rvalid),    32'(m_rv));
      chk("rdata",     32'(bus.rdata),     32'(m_rd));
      chk("err",       32'(bus.err),       32'(m_err));
      chk("init_done", 32'(bus.init_done), 32'(m_init));
      g_obs = bus.gnt;
      m_rv  = '0;
      m_err = 1'b0;
      if (!m_init) begin
         m_clr++;
         if (m_clr == DEPTH) m_init = 1'b1;
      end else if (g != '0) begin
         kv = '0;
         for (int j = 0; j < NC; j++) if (g[PW'(j)]) kv = PW'(j);
         a = t_addr[kv];
         if (t_we[kv]) begin
            if (int'(a) < DEPTH) m_mem[a] = t_wd[kv];
            else                 m_err = 1'b1;
         end else begin
            m_rv[kv] = 1'b1;
            m_rd     = (int'(a) < DEPTH) ? m_mem[a] : '0;
            m_err    = !(int'(a) < DEPTH);
         end
         m_rr = (int'(kv) + 1) % NC;
      end
      m_gnt_last = g;
      @(posedge clk);
      #1;
   endtask

   logic [NC-1:0] g;
   logic [NC-1:0] rr_a [6];
   logic [NC-1:0] rr_b [4];

   initial begin
      n_chk = 0; n_pass = 0;
      t_req = '0; t_we = '0;
      for (int k = 0; k < NC; k++) begin t_addr[k] = '0; t_wd[k] = '0; end
      rr_a[0] = 3'b001; rr_a[1] = 3'b010; rr_a[2] = 3'b100;
      rr_a[3] = 3'b001; rr_a[4] = 3'b010; rr_a[5] = 3'b100;
      rr_b[0] = 3'b001; rr_b[1] = 3'b100; rr_b[2] = 3'b001; rr_b[3] = 3'b100;
      model_reset();

      // reset state
      t_req = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",    32'(bus.gnt),       32'd0);
      chk("rst_rvalid", 32'(bus.rvalid),    32'd0);
      chk("rst_rdata",  32'(bus.rdata),     32'd0);
      chk("rst_err",    32'(bus.err),       32'd0);
      chk("rst_init",   32'(bus.init_done), 32'd0);
      rst_n = 1'b1;

      // zero-fill: gnt held low with all requests up
      repeat (DEPTH) cycle(g);
      chk("init_rise", 32'(bus.init_done), 32'd1);

      // round robin, all three requesting, then ch1 drops
      for (int i = 0; i < 6; i++) begin
         cycle(g);
         chk("rr_all", 32'(g), 32'(rr_a[i]));
      end
      t_req = 3'b101;
      for (int i = 0; i < 4; i++) begin
         cycle(g);
         chk("rr_drop", 32'(g), 32'(rr_b[i]));
      end

      // every word reads zero after clear
      t_req = 3'b001; t_we = '0;
      for (int a = 0; a < DEPTH; a++) begin
         t_addr[0] = AW'(a);
         cycle(g);
         chk("clr_rv", 32'(bus.rvalid), 32'd1);
         chk("clr_rd", 32'(bus.rdata),  32'd0);
      end

      // write A5 via ch0 then read via ch1
      t_req = 3'b001; t_we = 3'b001; t_addr[0] = 4'd3; t_wd[0] = 8'hA5;
      cycle(g);
      t_req = 3'b010; t_we = 3'b000; t_addr[1] = 4'd3;
      cycle(g);
      chk("wr_rd_rv", 32'(bus.rvalid), 32'b010);
      chk("wr_rd_rd", 32'(bus.rdata),  32'hA5);

      // out of range write then read
      t_req = 3'b001; t_we = 3'b001; t_addr[0] = 4'd13; t_wd[0] = 8'h77;
      cycle(g);
      chk("oor_w_err", 32'(bus.err),    32'd1);
      chk("oor_w_rv",  32'(bus.rvalid), 32'd0);
      t_we = 3'b000;
      cycle(g);
      chk("oor_r_err", 32'(bus.err),    32'd1);
      chk("oor_r_rv",  32'(bus.rvalid), 32'd1);
      chk("oor_r_rd",  32'(bus.rdata),  32'd0);
      t_addr[0] = 4'd1;
      cycle(g);
      chk("oor_alias", 32'(bus.rdata), 32'd0);
      chk("oor_noerr", 32'(bus.err),   32'd0);

      // random traffic; a channel holds its access until granted
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NC; k++) begin
            logic [PW-1:0] kv;
            kv = PW'(k);
            if (!t_req[kv] || m_gnt_last[kv]) begin
               t_req[kv]  = ($urandom_range(0, 3) != 0);
               t_we[kv]   = 1'($urandom_range(0, 1));
               t_addr[kv] = AW'($urandom_range(0, 15));
               t_wd[kv]   = W'($urandom);
            end
         end
         cycle(g);
      end

      // reset right after a read transfer
      t_req = 3'b001; t_we = 3'b001; t_addr[0] = 4'd5; t_wd[0] = 8'h5A;
      cycle(g);
      t_we = 3'b000;
      cycle(g);
      rst_n = 1'b0;
      #1;
      chk("mid_rvalid", 32'(bus.rvalid),    32'd0);
      chk("mid_rdata",  32'(bus.rdata),     32'd0);
      chk("mid_err",    32'(bus.err),       32'd0);
      chk("mid_init",   32'(bus.init_done), 32'd0);
      chk("mid_gnt",    32'(bus.gnt),       32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t_req = '1;
      repeat (DEPTH) cycle(g);
      t_req = 3'b010; t_we = '0;
      for (int a = 0; a < DEPTH; a++) begin
         t_addr[1] = AW'(a);
         cycle(g);
         chk("reclr_rd", 32'(bus.rdata),  32'd0);
         chk("reclr_rv", 32'(bus.rvalid), 32'b010);
      end

      // idle hold after a read of 3C
      t_req = 3'b100; t_we = 3'b100; t_addr[2] = 4'd7; t_wd[2] = 8'h3C;
      cycle(g);
      t_we = 3'b000;
      cycle(g);
      t_req = '0;
      repeat (10) begin
         cycle(g);
         chk("idle_rd",  32'(bus.rdata),  32'h3C);
         chk("idle_rv",  32'(bus.rvalid), 32'd0);
         chk("idle_gnt", 32'(bus.gnt),    32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
